sprite_layer: RTL and testbench
===============================

SPRITE_LAYER -- requirements
Module: sprite_layer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: bits per colour channel, matching the compositor layer inputs.
REQ-002 SHALL have parameter SPRITE_W, default 32: sprite width in pixels, a power of two.
REQ-003 SHALL have parameter SPRITE_H, default 32: sprite height in pixels, a power of two.
REQ-004 SHALL have parameter FRAMES, default 4: animation frames stored in ROM, a power of two.
REQ-005 SHALL have parameter ANIM_DIV, default 8: video frames per animation step, at least 1.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL have port hcount, input, 10 bits: current pixel column.
REQ-009 SHALL have port vcount, input, 10 bits: current pixel row.
REQ-010 SHALL have port active, input, 1 bit: the pixel is in the visible area.
REQ-011 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of each frame.
REQ-012 SHALL have port pos_x, input, 10 bits: requested sprite left column.
REQ-013 SHALL have port pos_y, input, 10 bits: requested sprite top row.
REQ-014 SHALL have port visible, input, 1 bit: sprite enable request.
REQ-015 SHALL have port anim_en, input, 1 bit: animation advance enable.
REQ-016 SHALL have port rom_addr, output, log2(FRAMES*SPRITE_W*SPRITE_H) bits: registered ROM address, laid out as {anim_frame, row, col}.
REQ-017 SHALL have port rom_data, input, 3*DEPTH+1 bits: {R,G,B,A} returned by a synchronous ROM with 1-cycle read latency.
REQ-018 SHALL have ports R, G, B, each output, DEPTH bits, and port A, output, 1 bit: the registered layer pixel, which feeds the compositor curr/prev inputs.

Function
REQ-019 SHALL update the latched copies lx, ly and lvis from pos_x, pos_y and visible only on cycles where frame_start=1; the new values SHALL take effect from the following cycle, so there is no tearing mid-frame.
REQ-020 SHALL compute hit = lvis & active & (hcount-lx) < SPRITE_W & (vcount-ly) < SPRITE_H, with each difference computed 11 bits wide and a negative result counted as a miss; sprites that extend past column 1023 or row 1023 are clipped and SHALL NOT wrap.
REQ-021 SHALL register rom_addr = {anim_frame, vcount-ly, hcount-lx} (truncated offsets) on every cycle, hit or miss.
REQ-022 SHALL delay hit through a 2-stage shift register so it stays aligned with rom_data.
REQ-023 SHALL register {R,G,B,A} = rom_data when the delayed hit=1, and otherwise {0,0,0,0}; total latency from input to output is 3 cycles (inputs in cycle n appear at the outputs in cycle n+3).
REQ-024 SHALL hold anim counter anim_div_cnt in range 0..ANIM_DIV-1 and anim_frame in range 0..FRAMES-1.
REQ-025 SHALL increment anim_div_cnt on frame_start when anim_en=1; when the count reaches ANIM_DIV-1 it SHALL clear to 0 and advance anim_frame, which wraps from FRAMES-1 to 0.
REQ-026 SHALL hold both animation counters when anim_en=0; they SHALL NOT clear.
REQ-027 SHALL let a frame_start that arrives during a pixel use the old latched position for that cycle's hit, and the old anim_frame for that cycle's rom_addr.
REQ-028 SHALL ignore frame_start while rst_n=0.
REQ-029 SHALL give the pipeline no stall or handshake; it runs continuously.

Reset
REQ-030 SHALL, on any rising edge with rst_n=0, set R, G, B, A, rom_addr, lx, ly, lvis, anim_div_cnt, anim_frame and the hit delay stages all to 0.
REQ-031 SHALL, when reset is asserted mid-frame, drive A=0 on the outputs from the next cycle on, and keep lvis=0 after release until the next frame_start, so no sprite pixel appears.

Verification
REQ-032 Scenario: pos=(100,50), visible=1, frame_start; then hcount=100, vcount=50, active=1 -> rom_addr=0 one cycle later, and outputs equal rom_data with A=rom alpha 3 cycles later.
REQ-033 Scenario: hcount=99 and hcount=132 on row 50 -> A=0 and RGB=0 at the outputs; hcount=131 -> hit, rom_addr col=31.
REQ-034 Scenario: pos_x changes to 200 mid-frame with no frame_start -> hits stay at column 100 until the next frame_start, then move to column 200.
REQ-035 Scenario: anim_en=1, ANIM_DIV=8 -> anim_frame advances on the 8th, 16th, 24th and 32nd frame_start and is 0 again after the 32nd; with anim_en=0 it holds.
REQ-036 Scenario: pos=(1000,1000), pixel (1010,1005) -> hit; pixel (2,1005) -> miss, with no wrap.
REQ-037 Scenario: rst_n low for one cycle mid-sprite -> A=0 on every following cycle until the next frame_start plus 3 cycles, and anim_frame=0.

Source files
------------

// File: rtl/sprite_layer.sv
// Single animated sprite layer: latches position once per frame, addresses a
// synchronous sprite ROM and emits a registered {R,G,B,A} pixel 3 cycles later.
module sprite_layer #(
  parameter int DEPTH    = 4,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [9:0]                                     hcount,
  input  logic [9:0]                                     vcount,
  input  logic                                           active,
  input  logic                                           frame_start,
  input  logic [9:0]                                     pos_x,
  input  logic [9:0]                                     pos_y,
  input  logic                                           visible,
  input  logic                                           anim_en,
  output logic [$clog2(FRAMES*SPRITE_W*SPRITE_H)-1:0]   rom_addr,
  input  logic [3*DEPTH:0]                               rom_data,
  output logic [DEPTH-1:0]                               R,
  output logic [DEPTH-1:0]                               G,
  output logic [DEPTH-1:0]                               B,
  output logic                                           A
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int AW = $clog2(FRAMES*SPRITE_W*SPRITE_H);

  localparam logic [DW-1:0] DIV_LAST   = DW'(ANIM_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);
  localparam logic [10:0]   W_LIMIT    = 11'(SPRITE_W);
  localparam logic [10:0]   H_LIMIT    = 11'(SPRITE_H);

  logic [9:0]          lx;
  logic [9:0]          ly;
  logic                lvis;
  logic [DW-1:0]       anim_div_cnt;
  logic [FW-1:0]       anim_frame;
  logic [10:0]         dx;
  logic [10:0]         dy;
  logic                hit;
  logic [1:0]          hit_d;
  logic [FW+YW+XW-1:0] addr_full;

  // Offsets are 11 bits so a pixel left of / above the sprite becomes a huge
  // unsigned value and fails the bound check instead of wrapping.
  always_comb begin
    dx        = {1'b0, hcount} - {1'b0, lx};
    dy        = {1'b0, vcount} - {1'b0, ly};
    hit       = lvis & active & (dx < W_LIMIT) & (dy < H_LIMIT);
    addr_full = {anim_frame, dy[YW-1:0], dx[XW-1:0]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lx   <= '0;
      ly   <= '0;
      lvis <= 1'b0;
    end else if (frame_start) begin
      lx   <= pos_x;
      ly   <= pos_y;
      lvis <= visible;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anim_div_cnt <= '0;
      anim_frame   <= '0;
    end else if (frame_start && anim_en) begin
      if (anim_div_cnt == DIV_LAST) begin
        anim_div_cnt <= '0;
        anim_frame   <= (anim_frame == FRAME_LAST) ? '0 : anim_frame + 1'b1;
      end else begin
        anim_div_cnt <= anim_div_cnt + 1'b1;
      end
    end
  end

  // hit is delayed two stages to line up with the ROM's one-cycle read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      hit_d    <= '0;
      R        <= '0;
      G        <= '0;
      B        <= '0;
      A        <= 1'b0;
    end else begin
      rom_addr <= addr_full[AW-1:0];
      hit_d    <= {hit_d[0], hit};
      if (hit_d[1]) begin
        {R, G, B, A} <= rom_data;
      end else begin
        {R, G, B, A} <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer with a behavioural synchronous ROM whose
// word encodes its own address, so every output pixel is traceable.
module tb_sprite_layer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        active;
  logic        frame_start;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        visible;
  logic        anim_en;
  logic [11:0] rom_addr;
  logic [12:0] rom_data;
  logic [3:0]  R;
  logic [3:0]  G;
  logic [3:0]  B;
  logic        A;

  int tests_run    = 0;
  int tests_failed = 0;

  sprite_layer dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .active(active), .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y),
    .visible(visible), .anim_en(anim_en), .rom_addr(rom_addr),
    .rom_data(rom_data), .R(R), .G(G), .B(B), .A(A)
  );

  always #5 clk = ~clk;

  // ROM word = {address, alpha}; texel column 5 is transparent.
  function automatic logic [12:0] rom_word(input logic [11:0] a);
    return {a, (a[4:0] != 5'd5)};
  endfunction

  always @(posedge clk) rom_data <= rom_word(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic act, input logic fs);
    hcount      = h;
    vcount      = v;
    active      = act;
    frame_start = fs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic pulse();
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b1);
    tick();
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
    tick();
  endtask

  // One isolated pixel: address one cycle later, pixel three cycles later.
  task automatic probe(input logic [9:0] h, input logic [9:0] v, input logic act,
                       input logic fs, input logic [11:0] exp_addr,
                       input logic exp_hit, input string tag);
    applyStimulus(h, v, act, fs);
    tick();
    checkOutput({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput({tag, "_pix"}, 32'({R, G, B, A}),
                exp_hit ? 32'(rom_word(exp_addr)) : 32'd0);
  endtask

  initial begin
    #300000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    pos_x   = 10'd0;
    pos_y   = 10'd0;
    visible = 1'b0;
    anim_en = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset_pix", 32'({R, G, B, A}), 32'd0);

    rst_n   = 1'b1;
    pos_x   = 10'd100;
    pos_y   = 10'd50;
    visible = 1'b1;
    pulse();

    probe(10'd100, 10'd50, 1'b1, 1'b0, 12'd0,   1'b1, "origin");
    probe(10'd99,  10'd50, 1'b1, 1'b0, 12'd31,  1'b0, "left_out");
    probe(10'd132, 10'd50, 1'b1, 1'b0, 12'd0,   1'b0, "right_out");
    probe(10'd131, 10'd50, 1'b1, 1'b0, 12'd31,  1'b1, "right_in");
    probe(10'd105, 10'd51, 1'b1, 1'b0, 12'd37,  1'b1, "transparent");
    probe(10'd100, 10'd81, 1'b1, 1'b0, 12'd992, 1'b1, "bottom_in");
    probe(10'd100, 10'd82, 1'b1, 1'b0, 12'd0,   1'b0, "bottom_out");
    probe(10'd100, 10'd50, 1'b0, 1'b0, 12'd0,   1'b0, "inactive");

    pos_x = 10'd200;
    probe(10'd100, 10'd50, 1'b1, 1'b0, 12'd0,  1'b1, "no_tear");
    probe(10'd200, 10'd50, 1'b1, 1'b0, 12'd4,  1'b0, "not_moved_yet");
    probe(10'd100, 10'd50, 1'b1, 1'b1, 12'd0,  1'b1, "fs_uses_old_pos");
    probe(10'd200, 10'd50, 1'b1, 1'b0, 12'd0,  1'b1, "moved");
    probe(10'd100, 10'd50, 1'b1, 1'b0, 12'd28, 1'b0, "old_pos_gone");

    visible = 1'b0;
    pulse();
    probe(10'd200, 10'd50, 1'b1, 1'b0, 12'd0, 1'b0, "hidden");
    visible = 1'b1;
    pulse();

    anim_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      pulse();
      if ((k % 8 == 7) || (k % 8 == 0))
        probe(10'd200, 10'd50, 1'b1, 1'b0, 12'(((k / 8) % 4) << 10), 1'b1,
              $sformatf("anim_%0d", k));
    end

    for (int k = 0; k < 5; k++) pulse();
    anim_en = 1'b0;
    for (int k = 0; k < 10; k++) pulse();
    probe(10'd200, 10'd50, 1'b1, 1'b0, 12'd0, 1'b1, "anim_hold");
    anim_en = 1'b1;
    pulse();
    pulse();
    probe(10'd200, 10'd50, 1'b1, 1'b0, 12'd0, 1'b1, "div_kept");
    pulse();
    probe(10'd200, 10'd50, 1'b1, 1'b0, 12'd1024, 1'b1, "div_advance");
    anim_en = 1'b0;

    pos_x = 10'd1000;
    pos_y = 10'd1000;
    pulse();
    probe(10'd1010, 10'd1005, 1'b1, 1'b0, 12'd1194, 1'b1, "clip_in");
    probe(10'd2,    10'd1005, 1'b1, 1'b0, 12'd1210, 1'b0, "no_wrap");
    probe(10'd1023, 10'd1023, 1'b1, 1'b0, 12'd1783, 1'b1, "corner");

    pos_x = 10'd100;
    pos_y = 10'd50;
    pulse();
    applyStimulus(10'd100, 10'd50, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("pre_reset_pix", 32'({R, G, B, A}), 32'(rom_word(12'd1024)));

    rst_n = 1'b0;
    applyStimulus(10'd100, 10'd50, 1'b1, 1'b1);
    tick();
    rst_n = 1'b1;
    applyStimulus(10'd100, 10'd50, 1'b1, 1'b0);
    checkOutput("rst_pix", 32'({R, G, B, A}), 32'd0);
    checkOutput("rst_addr", 32'(rom_addr), 32'd0);
    tick();
    checkOutput("rst_frame_zero", 32'(rom_addr), 32'd580);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("rst_alpha_%0d", k), 32'(A), 32'd0);
      tick();
    end

    applyStimulus(10'd100, 10'd50, 1'b1, 1'b1);
    tick();
    applyStimulus(10'd100, 10'd50, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("restart_wait_%0d", k), 32'(A), 32'd0);
      tick();
    end
    checkOutput("restart_pix", 32'({R, G, B, A}), 32'(rom_word(12'd0)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
